// File: rtl/frame_rx_sequencer_if.sv
// Byte-receiver to staging-register bus of frame_rx_sequencer.
// The master modport is the sequencer side; slave is the SPI receiver / staging side.
interface frame_rx_sequencer_if;
    logic       rdy;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic       commit;
    logic       blank;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    modport master (
        input  rdy, rx_byte,
        output wr_en, wr_idx, wr_data, commit, blank, frame_err, err_cnt, busy
    );

    modport slave (
        output rdy, rx_byte,
        input  wr_en, wr_idx, wr_data, commit, blank, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/frame_rx_sequencer.sv
// Turns received SPI bytes into staging writes plus a commit pulse per good frame, with an inter-byte timeout and no-frame watchdog.
// Optional FRAME_CKSUM_EN: a 9th XOR checksum byte is verified in a CHECK state before committing.
module frame_rx_sequencer #(
    parameter logic [7:0] SYNC_BYTE   = 8'h55,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         WDOG_CYC    = 1048576
) (
    input logic                  clk,
    input logic                  reset,
    frame_rx_sequencer_if.master bus
);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC);
    localparam int WCNT_W = $clog2(WDOG_CYC);
    localparam logic [TCNT_W-1:0] TO_FIRE = TCNT_W'(TIMEOUT_CYC - 2);
    localparam logic [WCNT_W-1:0] WD_FIRE = WCNT_W'(WDOG_CYC - 2);
    localparam logic [WCNT_W-1:0] WD_LAST = WCNT_W'(WDOG_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
`ifdef FRAME_CKSUM_EN
        S_CHECK,
`endif
        S_COMMIT
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0: rdy synchroniser (rdy is asynchronous to clk)
    logic       rdy_meta_p0;
    logic       rdy_sync_p0;
    logic       evt_p0;

    // Stage p1: edge history, byte event and captured byte
    logic       rdy_hist_p1;
    logic       vld_p1;
    logic [7:0] byte_p1;

    // Stage p2: sequencer state and registered outputs
    state_t            state;
    logic [3:0]        idx;
    logic [TCNT_W-1:0] tcnt;
    logic [WCNT_W-1:0] wcnt;
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [7:0]        wr_data;
    logic              commit;
    logic              blank;
    logic              frame_err;
    logic [7:0]        err_cnt;
    logic              busy;
`ifdef FRAME_CKSUM_EN
    logic [7:0]        xsum;
    logic [7:0]        cksum;
`endif

    assign evt_p0 = rdy_sync_p0 & ~rdy_hist_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_meta_p0 <= 1'b0;
            rdy_sync_p0 <= 1'b0;
            rdy_hist_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            rdy_meta_p0 <= bus.rdy;
            rdy_sync_p0 <= rdy_meta_p0;
            rdy_hist_p1 <= rdy_sync_p0;
            vld_p1      <= evt_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (evt_p0) byte_p1 <= bus.rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            tcnt      <= '0;
            wcnt      <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= 3'd0;
            wr_data   <= 8'd0;
            commit    <= 1'b0;
            blank     <= 1'b1;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            commit    <= 1'b0;
            frame_err <= 1'b0;

            // Watchdog saturates at its last count so blank holds until the next commit
            if (state == S_COMMIT) begin
                wcnt  <= '0;
                blank <= 1'b0;
            end else if (wcnt != WD_LAST) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == WD_FIRE) blank <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    if (vld_p1 && byte_p1 == SYNC_BYTE) begin
                        state <= S_RECV;
                        busy  <= 1'b1;
                        idx   <= 4'd1;
`ifdef FRAME_CKSUM_EN
                        xsum  <= 8'd0;
`endif
                    end
                end

                S_RECV: begin
                    if (vld_p1) begin
                        tcnt <= '0;
`ifdef FRAME_CKSUM_EN
                        if (idx == 4'd8) begin
                            cksum <= byte_p1;
                            state <= S_CHECK;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_idx  <= idx[2:0];
                            wr_data <= byte_p1;
                            idx     <= idx + 4'd1;
                            xsum    <= xsum ^ byte_p1;
                        end
`else
                        wr_en   <= 1'b1;
                        wr_idx  <= idx[2:0];
                        wr_data <= byte_p1;
                        idx     <= idx + 4'd1;
                        if (idx == 4'd7) state <= S_COMMIT;
`endif
                    end else if (tcnt == TO_FIRE) begin
                        // Partial staging writes are left in place; outputs only move on commit
                        tcnt      <= '0;
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

`ifdef FRAME_CKSUM_EN
                S_CHECK: begin
                    tcnt <= '0;
                    if (cksum == xsum) begin
                        state <= S_COMMIT;
                    end else begin
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
`endif

                S_COMMIT: begin
                    tcnt   <= '0;
                    commit <= 1'b1;
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en     = wr_en;
    assign bus.wr_idx    = wr_idx;
    assign bus.wr_data   = wr_data;
    assign bus.commit    = commit;
    assign bus.blank     = blank;
    assign bus.frame_err = frame_err;
    assign bus.err_cnt   = err_cnt;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_frame_rx_sequencer.sv
// Bench for frame_rx_sequencer: vector table of byte sequences, a write scoreboard, and hand-written timeout/watchdog/reset cases.
module tb_frame_rx_sequencer;
    localparam int TO = 32;
    localparam int WD = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;

    frame_rx_sequencer_if bus();

    frame_rx_sequencer #(
        .SYNC_BYTE  (8'h55),
        .TIMEOUT_CYC(TO),
        .WDOG_CYC   (WD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int wr_seen = 0, cm_seen = 0, ferr_seen = 0;
    int wr_cyc = 0, cm_cyc = 0;
    logic [10:0] exp_q[$];
    int m_idx = 0;
    logic [7:0] m_xor = 8'd0;

    typedef struct packed {
        logic [3:0]  n;
        logic [79:0] b;
        logic [3:0]  wr;
        logic [1:0]  cm;
        logic        busy;
        logic        blank;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [10:0] e;
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL wr_unexpected: got idx %0d data %0h, expected no write", bus.wr_idx, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_beat", 32'({bus.wr_idx, bus.wr_data}), 32'(e));
            end
        end
        if (bus.commit === 1'b1) begin
            cm_seen++;
            cm_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    // Reference framing model: pushes the staging write each byte should produce
    task automatic model_byte(input logic [7:0] b, output bit w);
        w = 1'b0;
        if (m_idx == 0) begin
            if (b == 8'h55) begin
                m_idx = 1;
                m_xor = 8'd0;
            end
        end else if (m_idx <= 7) begin
            exp_q.push_back({3'(m_idx), b});
            m_xor ^= b;
            m_idx++;
            w = 1'b1;
`ifndef FRAME_CKSUM_EN
            if (m_idx == 8) m_idx = 0;
`endif
        end else begin
            m_idx = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit w;
        int lat;
        model_byte(b, w);
        lat = 0;
        @(negedge clk);
        bus.rx_byte = b;
        bus.rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) bus.rdy = 1'b0;
            if (bus.wr_en === 1'b1 && lat == 0) lat = i;
        end
        if (w) check("wr_latency", lat, 4);
    endtask

    task automatic send_seq(input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[79-8*i -: 8]);
    endtask

    task automatic send_frame(input logic [79:0] bytes, input int n);
        send_seq(bytes, n);
`ifdef FRAME_CKSUM_EN
        if (m_idx == 8) send_byte(m_xor);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check({tag, "_wr_idx"}, 32'(bus.wr_idx), 0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        check({tag, "_commit"}, 32'(bus.commit), 0);
        check({tag, "_blank"}, 32'(bus.blank), 1);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 0);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w0, c0, f0, fc, bc;
        bit found;
        logic [7:0] e0;

        vecs[0] = '{n:4'd8,  b:80'h55_10_02_80_40_20_FF_01_00_00, wr:4'd7, cm:2'd1, busy:1'b0, blank:1'b0};
        vecs[1] = '{n:4'd10, b:80'hAA_00_55_11_22_33_44_55_66_77, wr:4'd7, cm:2'd1, busy:1'b0, blank:1'b0};
        vecs[2] = '{n:4'd2,  b:80'h12_34_00_00_00_00_00_00_00_00, wr:4'd0, cm:2'd0, busy:1'b0, blank:1'b0};
        vecs[3] = '{n:4'd3,  b:80'h55_A0_A1_00_00_00_00_00_00_00, wr:4'd2, cm:2'd0, busy:1'b1, blank:1'b0};
        vecs[4] = '{n:4'd5,  b:80'hA2_A3_A4_A5_A6_00_00_00_00_00, wr:4'd5, cm:2'd1, busy:1'b0, blank:1'b0};

        bus.rdy = 1'b0;
        bus.rx_byte = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            w0 = wr_seen; c0 = cm_seen; f0 = ferr_seen;
            send_frame(vecs[v].b, 32'(vecs[v].n));
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_writes", v), wr_seen - w0, 32'(vecs[v].wr));
            check($sformatf("v%0d_commits", v), cm_seen - c0, 32'(vecs[v].cm));
            check($sformatf("v%0d_errors", v), ferr_seen - f0, 0);
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'(vecs[v].busy));
            check($sformatf("v%0d_blank", v), 32'(bus.blank), 32'(vecs[v].blank));
            check($sformatf("v%0d_queue", v), exp_q.size(), 0);
        end

        // Inter-byte timeout mid-frame
        c0 = cm_seen; f0 = ferr_seen; found = 0; fc = 0;
        send_frame(80'h55_10_02_00_00_00_00_00_00_00, 3);
        for (int k = 0; k < TO + 16 && !found; k++) begin
            @(negedge clk);
            if (bus.frame_err === 1'b1) begin
                found = 1;
                fc = cyc;
            end
        end
        m_idx = 0;
        check("to_seen", 32'(found), 1);
        check("to_delay", fc - wr_cyc, TO - 1);
        @(posedge clk);
        #1;
        check("to_err_cnt", 32'(bus.err_cnt), 1);
        check("to_busy", 32'(bus.busy), 0);
        check("to_no_commit", cm_seen - c0, 0);
        check("to_one_pulse", ferr_seen - f0, 1);
        c0 = cm_seen;
        send_frame(80'h55_01_02_03_04_05_06_07_00_00, 8);
        repeat (2) @(posedge clk);
        #1;
        check("to_next_commit", cm_seen - c0, 1);
        check("to_next_blank", 32'(bus.blank), 0);

        // Watchdog after a commit
        found = 0; bc = 0;
        for (int k = 0; k < WD + 16 && !found; k++) begin
            @(negedge clk);
            if (bus.blank === 1'b1) begin
                found = 1;
                bc = cyc;
            end
        end
        check("wd_seen", 32'(found), 1);
        check("wd_delay", bc - cm_cyc, WD - 1);
        c0 = cm_seen;
        send_frame(80'h55_C1_C2_C3_C4_C5_C6_C7_00_00, 8);
        repeat (2) @(posedge clk);
        #1;
        check("wd_clear_commit", cm_seen - c0, 1);
        check("wd_clear_blank", 32'(bus.blank), 0);

        // Reset in the middle of a frame
        send_seq(80'h55_10_02_80_00_00_00_00_00_00, 4);
        c0 = cm_seen; f0 = ferr_seen;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_idx = 0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_commit", cm_seen - c0, 0);
        check("mid_rst_no_err", ferr_seen - f0, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        send_frame(80'h55_10_02_80_40_20_FF_01_00_00, 8);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_recommit", cm_seen - c0, 1);
        check("mid_rst_blank", 32'(bus.blank), 0);

`ifdef FRAME_CKSUM_EN
        // XOR of 10,02,80,40,20,FF,01 is 0C
        c0 = cm_seen; f0 = ferr_seen; e0 = bus.err_cnt;
        send_seq(80'h55_10_02_80_40_20_FF_01_00_00, 8);
        send_byte(8'h0C);
        repeat (2) @(posedge clk);
        #1;
        check("ck_good_commit", cm_seen - c0, 1);
        check("ck_good_err", ferr_seen - f0, 0);
        c0 = cm_seen; f0 = ferr_seen;
        send_seq(80'h55_10_02_80_40_20_FF_01_00_00, 8);
        send_byte(8'h0D);
        repeat (2) @(posedge clk);
        #1;
        check("ck_bad_commit", cm_seen - c0, 0);
        check("ck_bad_err", ferr_seen - f0, 1);
        check("ck_bad_err_cnt", 32'(bus.err_cnt), 32'(e0 + 8'd1));
`endif

        // Error counter saturation
        for (int k = 0; k < 300 && bus.err_cnt !== 8'hFF; k++) begin
            send_byte(8'h55);
            m_idx = 0;
            repeat (TO + 2) @(posedge clk);
            #1;
        end
        check("sat_reach", 32'(bus.err_cnt), 32'hFF);
        f0 = ferr_seen;
        send_byte(8'h55);
        m_idx = 0;
        repeat (TO + 2) @(posedge clk);
        #1;
        check("sat_pulse", ferr_seen - f0, 1);
        check("sat_hold", 32'(bus.err_cnt), 32'hFF);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
